// File: rtl/countdown_timer_pkg.sv
// rtl/countdown_timer_pkg.sv - shared state encoding, field type and clamp helper for the mm:ss countdown timer
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam int unsigned MAX_VAL = 59;

  typedef logic [5:0] time_field_t;

  function automatic time_field_t clamp_field(input time_field_t v, input time_field_t max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - preset/strobe inputs and mm:ss/status outputs of the countdown timer
interface countdown_timer_if;
  import timer_pkg::*;

  time_field_t set_min;
  time_field_t set_sec;
  logic        load;
  logic        start;
  logic        pause;
  time_field_t min_out;
  time_field_t sec_out;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output set_min, set_sec, load, start, pause,
    input  min_out, sec_out, running, done, expired
  );

  modport slave (
    input  set_min, set_sec, load, start, pause,
    output min_out, sec_out, running, done, expired
  );

endinterface

// File: rtl/countdown_timer_prescaler.sv
// rtl/countdown_timer_prescaler.sv - one_sec_prescaler: divides clk down to a one-cycle tick every TICK_DIV cycles
module one_sec_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  // clr outranks en so a load in the tick cycle still restarts the second cleanly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - mm:ss countdown timer with expiry flag; COUNTDOWN_AUTO_RELOAD_EN adds shadow-value auto reload
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  countdown_timer_if.slave bus
);

  localparam time_field_t MAX_F = time_field_t'(MAX_VAL);

  state_t      state_q, state_d;
  time_field_t min_q, sec_q, min_d, sec_d;
  time_field_t dec_min, dec_sec;
  time_field_t reload_min, reload_sec;
  logic        done_q, done_d, exp_q, exp_d, run_q;
  logic        tick, is_zero, dec_zero, reload_ok, expire_now, presc_clr;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  time_field_t shadow_min_q, shadow_sec_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_min_q <= '0;
      shadow_sec_q <= '0;
    end else if (bus.load) begin
      shadow_min_q <= clamp_field(bus.set_min, MAX_F);
      shadow_sec_q <= clamp_field(bus.set_sec, MAX_F);
    end
  end

  assign reload_min = shadow_min_q;
  assign reload_sec = shadow_sec_q;
  assign reload_ok  = (shadow_min_q != '0) || (shadow_sec_q != '0);
`else
  assign reload_min = '0;
  assign reload_sec = '0;
  assign reload_ok  = 1'b0;
`endif

  assign is_zero    = (min_q == '0) && (sec_q == '0);
  assign dec_zero   = (dec_min == '0) && (dec_sec == '0);
  assign expire_now = tick && dec_zero && !reload_ok;
  assign presc_clr  = bus.load || ((state_q == IDLE) && (state_d == RUN));

  one_sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Borrow: seconds first, then take one minute and refill seconds
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q != '0) begin
      dec_sec = sec_q - 6'd1;
    end else if (min_q != '0) begin
      dec_min = min_q - 6'd1;
      dec_sec = MAX_F;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
      exp_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
      exp_q   <= exp_d;
      run_q   <= (state_d == RUN);
    end
  end

  // Expiry is resolved before start/pause so a pause in the final tick cycle cannot mask it
  always_comb begin
    state_d = state_q;
    if (bus.load) begin
      state_d = IDLE;
    end else if (expire_now) begin
      state_d = EXPIRED;
    end else if (bus.start) begin
      if (((state_q == IDLE) || (state_q == PAUSED)) && !is_zero) begin
        state_d = RUN;
      end
    end else if (bus.pause && (state_q == RUN)) begin
      state_d = PAUSED;
    end
  end

  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    done_d = 1'b0;
    exp_d  = exp_q;
    if (bus.load) begin
      min_d = clamp_field(bus.set_min, MAX_F);
      sec_d = clamp_field(bus.set_sec, MAX_F);
      exp_d = 1'b0;
    end else if (tick) begin
      if (dec_zero) begin
        done_d = 1'b1;
        if (reload_ok) begin
          min_d = reload_min;
          sec_d = reload_sec;
        end else begin
          min_d = '0;
          sec_d = '0;
          exp_d = 1'b1;
        end
      end else begin
        min_d = dec_min;
        sec_d = dec_sec;
      end
    end
  end

  assign bus.min_out = min_q;
  assign bus.sec_out = sec_q;
  assign bus.running = run_q;
  assign bus.done    = done_q;
  assign bus.expired = exp_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer against a seconds-total reference model
module tb_countdown_timer;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  typedef struct {
    int mn;
    int sc;
    bit run;
    bit dn;
    bit ex;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  int total, mode, phase, shadow;
  bit exp_flag;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    total = 0; mode = M_IDLE; phase = 0; shadow = 0; exp_flag = 0;
  endtask

  // Remaining time is held as a plain count of seconds; the display is derived from it
  task automatic model_step(input bit ld, input bit st, input bit ps, input int smin, input int ssec, output exp_t e);
    bit tick, expired_now;
    e.dn = 0;
    expired_now = 0;
    tick = (mode == M_RUN) && (phase == TICK_DIV - 1);
    if (ld) begin
      total = ((smin > 59) ? 59 : smin) * 60 + ((ssec > 59) ? 59 : ssec);
      shadow = total; mode = M_IDLE; phase = 0; exp_flag = 0;
    end else begin
      if (mode == M_RUN) phase = (phase + 1) % TICK_DIV;
      if (tick) begin
        total = total - 1;
        if (total == 0) begin
          e.dn = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (shadow != 0) total = shadow;
          else begin mode = M_EXP; exp_flag = 1; expired_now = 1; end
`else
          mode = M_EXP; exp_flag = 1; expired_now = 1;
`endif
        end
      end
      if (!expired_now) begin
        if (st) begin
          if ((mode == M_IDLE || mode == M_PAUSED) && total != 0) begin
            if (mode == M_IDLE) phase = 0;
            mode = M_RUN;
          end
        end else if (ps && mode == M_RUN) begin
          mode = M_PAUSED;
        end
      end
    end
    e.mn = total / 60;
    e.sc = total % 60;
    e.run = (mode == M_RUN);
    e.ex = exp_flag;
  endtask

  task automatic cyc(input bit ld, input bit st, input bit ps, input int smin, input int ssec);
    exp_t e;
    @(negedge clk);
    bus.load = ld; bus.start = st; bus.pause = ps;
    bus.set_min = 6'(smin); bus.set_sec = 6'(ssec);
    model_step(ld, st, ps, smin, ssec, e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".min"}, bus.min_out, 0);
    cmp({tag, ".sec"}, bus.sec_out, 0);
    cmp({tag, ".running"}, bus.running, 0);
    cmp({tag, ".done"}, bus.done, 0);
    cmp({tag, ".expired"}, bus.expired, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.load = 0; bus.start = 0; bus.pause = 0;
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("held_reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every clock the DUT presents a fresh registered output set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        cmp("min_out", bus.min_out, e.mn);
        cmp("sec_out", bus.sec_out, e.sc);
        cmp("running", bus.running, e.run);
        cmp("done", bus.done, e.dn);
        cmp("expired", bus.expired, e.ex);
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.load = 0; bus.start = 0; bus.pause = 0; bus.set_min = '0; bus.set_sec = '0;
    model_reset();
    #3 check_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    idle(3);

    cyc(1, 0, 0, 1, 2);
    cyc(0, 1, 0, 0, 0);
    idle(62 * TICK_DIV + 4);
    cyc(0, 1, 0, 0, 0);
    idle(3);

    cyc(1, 0, 0, 63, 60);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(6);

    cyc(1, 0, 0, 0, 5);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    idle(20);
    cyc(0, 1, 0, 0, 0);
    idle(4);

    cyc(1, 1, 0, 0, 3);
    idle(2);
    cyc(0, 1, 0, 0, 0);
    idle(3);
    cyc(0, 0, 1, 0, 0);
    idle(3);
    cyc(0, 1, 0, 0, 0);
    idle(3 * TICK_DIV + 2);
    cyc(1, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 0);
    idle(4 * TICK_DIV + 2);

    cyc(1, 0, 0, 2, 0);
    cyc(0, 1, 0, 0, 0);
    idle(10);
    do_reset();
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      bit ld, st, ps;
      int sm, ss;
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      ps = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) begin
        sm = $urandom_range(0, 63);
        ss = $urandom_range(0, 63);
      end else begin
        sm = 0;
        ss = $urandom_range(0, 12);
      end
      cyc(ld, st, ps, sm, ss);
      if (i == 1500) do_reset();
    end
    idle(2);

    @(negedge clk);
    bus.load = 0; bus.start = 0; bus.pause = 0;
    repeat (3) @(posedge clk);
    #2 cmp("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Minutes:seconds countdown timer. It is the down-counting counterpart of the up-counting seconds/minutes clock chain.
- It loads a preset mm:ss value and decrements once per second, borrowing from minutes into seconds.
- At 00:00 it flags expiry.
- It sits beside the clock counters and drives the same display path, using the same 6-bit 0..59 field format.

Parameters:
- TICK_DIV, 50000000: clk cycles per one-second tick. Legal range is 2 or more.
- MAX_VAL, 59: highest legal value of a minutes or seconds field.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- set_min  in  6  preset minutes, sampled on load.
- set_sec  in  6  preset seconds, sampled on load.
- load  in  1  one-cycle strobe that loads the preset and aborts any run.
- start  in  1  one-cycle strobe that starts or resumes counting.
- pause  in  1  one-cycle strobe that freezes counting.
- min_out  out  6  current minutes.
- sec_out  out  6  current seconds.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching 00:00.
- expired  out  1  level, high from 00:00 until the next load.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; min_out=0, sec_out=0, running=0, done=0, expired=0; prescaler=0.
- States: IDLE, RUN, PAUSED, EXPIRED. running is a registered output equal to (state==RUN).
- Strobe priority within one cycle: load > start > pause.
- load (any state):
  - next cycle min_out=min(set_min, MAX_VAL) and sec_out=min(set_sec, MAX_VAL), so out-of-range inputs clamp to 59;
  - state=IDLE, expired=0, prescaler=0.
- start:
  - IDLE→RUN and PAUSED→RUN, but only if the value is not 00:00; with 00:00 the start is ignored.
  - start in RUN or EXPIRED is ignored.
  - The prescaler is cleared on IDLE→RUN, so the first decrement lands exactly TICK_DIV cycles after the start strobe.
  - On PAUSED→RUN the prescaler resumes from its held count.
- pause: RUN→PAUSED, prescaler held; ignored in every other state.
- Prescaler:
  - counts 0..TICK_DIV-1 only in RUN;
  - tick is asserted when the count equals TICK_DIV-1, and the count then wraps to 0;
  - a tick arriving in the same cycle as pause still decrements, because the tick is evaluated before the state change.
- Decrement on tick:
  - if sec_out>0: sec_out-1;
  - otherwise, if min_out>0: min_out-1 and sec_out=MAX_VAL.
- Reaching 00:00: on the edge where the decrement produces 00:00, the following all update together:
  - the outputs show 00:00;
  - done=1 for exactly one cycle;
  - expired=1;
  - state=EXPIRED;
  - running=0.
- EXPIRED: holds 00:00 and expired=1 until load. done never re-fires while in EXPIRED.
- All outputs are registered. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - the last load values are kept in shadow registers;
  - on reaching 00:00 the timer pulses done, reloads the shadow value on that same edge (the outputs never show 00:00 unless the shadow value is 00:00), and stays in RUN;
  - expired is never set except when the shadow value is 00:00.
- Undefined: behaviour exactly as above; no shadow registers are built.

Decomposition:
- Package timer_pkg:
  - state enum (IDLE, RUN, PAUSED, EXPIRED);
  - MAX_VAL constant;
  - 6-bit field typedef time_field_t.
- Sub-module one_sec_prescaler, parameter TICK_DIV, with ports:
  - clk, reset, en, clr as inputs;
  - tick as output.
- The FSM and the borrow arithmetic stay in countdown_timer.

Test Plan (all scenarios with TICK_DIV=4):
- Reset: assert reset=0 mid-run → outputs immediately 0, running=0, expired=0. After release, with no strobes, the outputs stay 00:00.
- Load and run:
  - stimulus: load 01:02, then start;
  - sec_out=01 exactly 4 cycles after start, then 00 at 8 cycles;
  - at 12 cycles the outputs show 00:59 (borrow);
  - done pulses once at 00:00 after 62 ticks total, expired=1, running=0.
- Clamp and zero start:
  - load set_min=63, set_sec=60 → 59:59;
  - load 00:00 then start → state stays IDLE, running=0, no done.
- Pause and resume:
  - start at 00:05 and pause 2 cycles after start;
  - hold 20 cycles → value unchanged;
  - start → next decrement arrives 2 cycles later, because the held prescaler count is retained.
- Simultaneous strobes:
  - load+start in the same cycle → the load wins, state IDLE;
  - pause in the tick cycle → the decrement happens, then PAUSED;
  - load during EXPIRED → expired clears on the next cycle.
- COUNTDOWN_AUTO_RELOAD_EN:
  - load 00:02, start → done pulses every 8 cycles and the outputs cycle 02→01→02;
  - expired stays 0.
